sim_sequencer: RTL and testbench
================================

SIM_SEQUENCER -- requirements
Module: sim_sequencer

Interface
REQ-001 Parameter NUM_LANES, default 4: number of parallel pusher/scatterer lanes, 1..16.
REQ-002 Parameter CNT_W, default 32: width of the step counter and step limit.
REQ-003 Parameter DIV_W, default 8: width of the solve-decimation field.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  begin a run; honoured only in IDLE.
REQ-007 abort  in  1  terminate the current run.
REQ-008 num_steps  in  CNT_W  step limit, sampled into steps_q on an accepted start.
REQ-009 solve_div  in  DIV_W  field solve every solve_div steps; sampled into div_q on an accepted start; 0 is treated as 1.
REQ-010 pusher_done  in  NUM_LANES  per-lane push-complete, level or pulse.
REQ-011 scatter_done  in  NUM_LANES  per-lane scatter-complete, level or pulse.
REQ-012 solver_done  in  1  field solve complete.
REQ-013 cnt_out  out  CNT_W  completed-push count of the current or last run.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 run_done  out  1  one-cycle pulse on normal run completion.
REQ-016 ui_valid  out  1  host access to particle/field memory permitted.
REQ-017 fifo_ready, first, start_solve, rst_pusher, rst_scatterer, rst_solver  out  1 each  stage control, as in REQ-020..027.

Function
REQ-018 States: IDLE, PUSH, SCATTER, RST_SOLVE, SOLVE; all outputs are registered.
REQ-019 IDLE + start + num_steps!=0 -> PUSH; cnt=0, div_cnt=0, first=1, fifo_ready=1, ui_valid=0.
REQ-020 IDLE + start + num_steps==0 -> stay IDLE; run_done pulses the next cycle; cnt unchanged.
REQ-021 Lane completion: a sticky NUM_LANES mask, cleared on entry to PUSH/SCATTER, ORs in the state's done vector each cycle; the state completes in the cycle where (mask | done) is all ones.
REQ-022 PUSH complete -> SCATTER; cnt+=1 (wraps modulo 2^CNT_W), fifo_ready=0, first=0, rst_pusher=1 for exactly one cycle.
REQ-023 SCATTER complete and cnt==steps_q -> IDLE; ui_valid=1, run_done=1 for one cycle.
REQ-024 SCATTER complete, cnt!=steps_q, div_cnt==div_q-1 -> RST_SOLVE; div_cnt=0, rst_solver=1 for one cycle.
REQ-025 SCATTER complete, cnt!=steps_q, otherwise -> PUSH (solve skipped); div_cnt+=1, rst_scatterer=1 for one cycle, fifo_ready=1.
REQ-026 RST_SOLVE -> SOLVE unconditionally after one cycle; start_solve=1 for exactly one cycle.
REQ-027 SOLVE + solver_done -> PUSH; rst_scatterer=1 for one cycle, fifo_ready=1.
REQ-028 abort in any non-IDLE state -> IDLE next cycle; rst_pusher, rst_scatterer, rst_solver each=1 for one cycle; fifo_ready=0, start_solve=0, ui_valid=1; no run_done; cnt holds.
REQ-029 abort in IDLE has no effect; start outside IDLE is ignored.
REQ-030 Simultaneous abort and any done: abort wins. Simultaneous start and abort in IDLE: start wins.
REQ-031 num_steps and solve_div changes during a run have no effect.

Reset
REQ-032 While rst_n=0: state=IDLE, cnt=0, div_cnt=0, masks=0, ui_valid=1, first=1, fifo_ready=0, start_solve=0, busy=0, run_done=0.
REQ-033 While rst_n=0: rst_pusher=rst_scatterer=rst_solver=1; all three go to 0 in the first cycle after release.
REQ-034 rst_n low mid-run overrides every other input and state in that cycle.

Verification
REQ-035 NUM_LANES=4, num_steps=3, solve_div=1, all dones single-cycle -> state order PUSH,SCATTER,RST_SOLVE,SOLVE x2, then PUSH,SCATTER,IDLE; cnt_out=3; one run_done; first high only in the first PUSH.
REQ-036 solve_div=3, num_steps=7 -> start_solve pulses exactly twice (after steps 3 and 6); each skipped solve shows one rst_scatterer pulse and no rst_solver pulse.
REQ-037 Lanes 0..3 pulse pusher_done on cycles 5,2,9,2 after PUSH entry -> SCATTER entered exactly one cycle after the lane-0 and lane-2 pulses (cycles 5 and 9) have both been seen, i.e. after cycle 9; cnt increments once.
REQ-038 abort asserted in the same cycle as solver_done -> IDLE; three reset pulses; no run_done; cnt_out holds its value.
REQ-039 start with num_steps=0 -> busy stays 0; run_done pulses once; no stage control output toggles.
REQ-040 rst_n low for one cycle while in SCATTER -> REQ-032 values next cycle; rst_* fall to 0 in the cycle after release; start then begins a clean run with cnt=0.

Source files
------------

// File: rtl/sim_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : sim_sequencer_if
// Description : Control/status bundle between a host and the PIC simulation
//               sequencer. The host side drives run control and per-lane
//               completion flags; the sequencer side returns stage controls.
// Revision    : 1.0 - initial release
// ============================================================================
interface sim_sequencer_if #(
  parameter int NUM_LANES = 4,
  parameter int CNT_W     = 32,
  parameter int DIV_W     = 8
);
  logic                 start;
  logic                 abort;
  logic [CNT_W-1:0]     num_steps;
  logic [DIV_W-1:0]     solve_div;
  logic [NUM_LANES-1:0] pusher_done;
  logic [NUM_LANES-1:0] scatter_done;
  logic                 solver_done;

  logic [CNT_W-1:0]     cnt_out;
  logic                 busy;
  logic                 run_done;
  logic                 ui_valid;
  logic                 fifo_ready;
  logic                 first;
  logic                 start_solve;
  logic                 rst_pusher;
  logic                 rst_scatterer;
  logic                 rst_solver;

  // Host / environment side
  modport master (
    output start, abort, num_steps, solve_div, pusher_done, scatter_done, solver_done,
    input  cnt_out, busy, run_done, ui_valid, fifo_ready, first, start_solve,
           rst_pusher, rst_scatterer, rst_solver
  );

  // Sequencer side
  modport slave (
    input  start, abort, num_steps, solve_div, pusher_done, scatter_done, solver_done,
    output cnt_out, busy, run_done, ui_valid, fifo_ready, first, start_solve,
           rst_pusher, rst_scatterer, rst_solver
  );
endinterface
`default_nettype wire

// File: rtl/sim_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sim_sequencer
// Description : Time-step sequencer for a particle-in-cell engine. Each step
//               runs PUSH then SCATTER across NUM_LANES lanes; every div_q
//               steps a field solve (RST_SOLVE, SOLVE) is inserted. All
//               outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module sim_sequencer #(
  parameter int NUM_LANES = 4,
  parameter int CNT_W     = 32,
  parameter int DIV_W     = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  sim_sequencer_if.slave  bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PUSH      = 3'd1;
  localparam logic [2:0] S_SCATTER   = 3'd2;
  localparam logic [2:0] S_RST_SOLVE = 3'd3;
  localparam logic [2:0] S_SOLVE     = 3'd4;

  logic [2:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     steps_q;
  logic [DIV_W-1:0]     div_cnt;
  logic [DIV_W-1:0]     div_q;
  logic [NUM_LANES-1:0] mask;
  logic [NUM_LANES-1:0] done_vec;
  logic                 lanes_done;

  logic busy;
  logic run_done;
  logic ui_valid;
  logic first;
  logic fifo_ready;
  logic start_solve;
  logic rst_pusher;
  logic rst_scatterer;
  logic rst_solver;

  // Select the completion vector of the active lane stage and test for all lanes done
  always_comb begin
    done_vec = '0;
    if (state == S_PUSH) begin
      done_vec = bus.pusher_done;
    end else if (state == S_SCATTER) begin
      done_vec = bus.scatter_done;
    end
    lanes_done = &(mask | done_vec);
  end

  // Sequencer state, counters, sticky lane mask and registered stage controls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      steps_q       <= '0;
      div_cnt       <= '0;
      div_q         <= '0;
      mask          <= '0;
      busy          <= 1'b0;
      run_done      <= 1'b0;
      ui_valid      <= 1'b1;
      first         <= 1'b1;
      fifo_ready    <= 1'b0;
      start_solve   <= 1'b0;
      rst_pusher    <= 1'b1;
      rst_scatterer <= 1'b1;
      rst_solver    <= 1'b1;
    end else begin
      // Pulse outputs default low; a branch below raises them for one cycle
      run_done      <= 1'b0;
      start_solve   <= 1'b0;
      rst_pusher    <= 1'b0;
      rst_scatterer <= 1'b0;
      rst_solver    <= 1'b0;

      if ((state != S_IDLE) && bus.abort) begin
        // Abort takes priority over any completion seen this cycle
        state         <= S_IDLE;
        busy          <= 1'b0;
        mask          <= '0;
        fifo_ready    <= 1'b0;
        ui_valid      <= 1'b1;
        rst_pusher    <= 1'b1;
        rst_scatterer <= 1'b1;
        rst_solver    <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start) begin
              if (bus.num_steps != '0) begin
                state      <= S_PUSH;
                busy       <= 1'b1;
                steps_q    <= bus.num_steps;
                div_q      <= (bus.solve_div == '0) ? DIV_W'(1) : bus.solve_div;
                cnt        <= '0;
                div_cnt    <= '0;
                mask       <= '0;
                first      <= 1'b1;
                fifo_ready <= 1'b1;
                ui_valid   <= 1'b0;
              end else begin
                // Zero-length run completes immediately without leaving IDLE
                run_done <= 1'b1;
              end
            end
          end

          S_PUSH: begin
            if (lanes_done) begin
              state      <= S_SCATTER;
              mask       <= '0;
              cnt        <= cnt + CNT_W'(1);
              fifo_ready <= 1'b0;
              first      <= 1'b0;
              rst_pusher <= 1'b1;
            end else begin
              mask <= mask | done_vec;
            end
          end

          S_SCATTER: begin
            if (lanes_done) begin
              mask <= '0;
              if (cnt == steps_q) begin
                state    <= S_IDLE;
                busy     <= 1'b0;
                ui_valid <= 1'b1;
                run_done <= 1'b1;
              end else if (div_cnt == (div_q - DIV_W'(1))) begin
                state      <= S_RST_SOLVE;
                div_cnt    <= '0;
                rst_solver <= 1'b1;
              end else begin
                // Solve skipped this step; go straight back to pushing
                state         <= S_PUSH;
                div_cnt       <= div_cnt + DIV_W'(1);
                rst_scatterer <= 1'b1;
                fifo_ready    <= 1'b1;
              end
            end else begin
              mask <= mask | done_vec;
            end
          end

          S_RST_SOLVE: begin
            state       <= S_SOLVE;
            start_solve <= 1'b1;
          end

          S_SOLVE: begin
            if (bus.solver_done) begin
              state         <= S_PUSH;
              mask          <= '0;
              rst_scatterer <= 1'b1;
              fifo_ready    <= 1'b1;
            end
          end

          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.cnt_out       = cnt;
  assign bus.busy          = busy;
  assign bus.run_done      = run_done;
  assign bus.ui_valid      = ui_valid;
  assign bus.first         = first;
  assign bus.fifo_ready    = fifo_ready;
  assign bus.start_solve   = start_solve;
  assign bus.rst_pusher    = rst_pusher;
  assign bus.rst_scatterer = rst_scatterer;
  assign bus.rst_solver    = rst_solver;

endmodule
`default_nettype wire

// File: tb/tb_sim_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sim_sequencer
// Description : Directed self-checking bench for sim_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sim_sequencer;

  localparam int NUM_LANES = 4;
  localparam int CNT_W     = 32;
  localparam int DIV_W     = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  sim_sequencer_if #(.NUM_LANES(NUM_LANES), .CNT_W(CNT_W), .DIV_W(DIV_W)) bus ();

  sim_sequencer #(.NUM_LANES(NUM_LANES), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse / activity counters sampled on the falling edge
  logic clr = 1'b1;
  int   n_run_done, n_start_solve, n_rst_p, n_rst_sc, n_rst_sv, n_busy, n_first, n_fr_tog;
  logic prev_fr;

  always @(negedge clk) begin
    if (clr) begin
      n_run_done = 0; n_start_solve = 0; n_rst_p = 0; n_rst_sc = 0; n_rst_sv = 0;
      n_busy = 0; n_first = 0; n_fr_tog = 0;
      prev_fr = bus.fifo_ready;
    end else begin
      if (bus.run_done)              n_run_done++;
      if (bus.start_solve)           n_start_solve++;
      if (bus.rst_pusher)            n_rst_p++;
      if (bus.rst_scatterer)         n_rst_sc++;
      if (bus.rst_solver)            n_rst_sv++;
      if (bus.busy)                  n_busy++;
      if (bus.busy && bus.first)     n_first++;
      if (bus.fifo_ready != prev_fr) n_fr_tog++;
      prev_fr = bus.fifo_ready;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counters();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic start_run(input logic [CNT_W-1:0] n, input logic [DIV_W-1:0] d);
    bus.num_steps = n;
    bus.solve_div = d;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic set_levels(input logic v);
    bus.pusher_done  = {NUM_LANES{v}};
    bus.scatter_done = {NUM_LANES{v}};
    bus.solver_done  = v;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int i;
    i = 0;
    while (bus.busy && i < budget) begin
      tick();
      i++;
    end
    check(tag, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pd;
    int         seen_at;

    bus.start = 1'b0; bus.abort = 1'b0; bus.num_steps = '0; bus.solve_div = '0;
    set_levels(1'b0);

    // Reset values
    rst_n = 1'b0;
    tick(); tick();
    check("rst_busy",        bus.busy,          0);
    check("rst_ui_valid",    bus.ui_valid,      1);
    check("rst_first",       bus.first,         1);
    check("rst_fifo_ready",  bus.fifo_ready,    0);
    check("rst_start_solve", bus.start_solve,   0);
    check("rst_run_done",    bus.run_done,      0);
    check("rst_cnt",         bus.cnt_out,       0);
    check("rst_rst_pusher",  bus.rst_pusher,    1);
    check("rst_rst_scat",    bus.rst_scatterer, 1);
    check("rst_rst_solver",  bus.rst_solver,    1);
    rst_n = 1'b1;
    tick();
    check("rel_rst_pusher",  bus.rst_pusher,    0);
    check("rel_rst_scat",    bus.rst_scatterer, 0);
    check("rel_rst_solver",  bus.rst_solver,    0);

    // Abort while idle does nothing
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("idle_abort_rst_p", bus.rst_pusher, 0);
    check("idle_abort_busy",  bus.busy,       0);

    // Three steps, solve every step, single-cycle dones
    clr_counters();
    start_run(32'd3, 8'd1);
    check("r1_busy",  bus.busy,       1);
    check("r1_fifo",  bus.fifo_ready, 1);
    check("r1_first", bus.first,      1);
    check("r1_uiv",   bus.ui_valid,   0);
    check("r1_cnt0",  bus.cnt_out,    0);
    for (int s = 1; s <= 3; s++) begin
      bus.pusher_done = '1; tick(); bus.pusher_done = '0;
      check("r1_push_cnt",    bus.cnt_out,    s);
      check("r1_push_rstp",   bus.rst_pusher, 1);
      check("r1_push_fifo",   bus.fifo_ready, 0);
      check("r1_push_first",  bus.first,      0);
      bus.scatter_done = '1; tick(); bus.scatter_done = '0;
      if (s < 3) begin
        check("r1_rst_solver", bus.rst_solver, 1);
        tick();
        check("r1_start_solve", bus.start_solve, 1);
        bus.solver_done = 1'b1; tick(); bus.solver_done = 1'b0;
        check("r1_solve_rstsc", bus.rst_scatterer, 1);
        check("r1_solve_fifo",  bus.fifo_ready,    1);
        check("r1_solve_ss0",   bus.start_solve,   0);
      end else begin
        check("r1_run_done", bus.run_done, 1);
        check("r1_end_busy", bus.busy,     0);
        check("r1_end_uiv",  bus.ui_valid, 1);
      end
    end
    tick();
    check("r1_run_done_low", bus.run_done,   0);
    check("r1_n_run_done",   n_run_done,     1);
    check("r1_n_first",      n_first,        1);
    check("r1_n_solve",      n_start_solve,  2);

    // Seven steps, solve every third step, done flags held as levels
    clr_counters();
    start_run(32'd7, 8'd3);
    set_levels(1'b1);
    wait_idle(100, "r2_timeout");
    set_levels(1'b0);
    tick();
    check("r2_cnt",      bus.cnt_out,   7);
    check("r2_n_solve",  n_start_solve, 2);
    check("r2_n_rstsv",  n_rst_sv,      2);
    check("r2_n_rstsc",  n_rst_sc,      6);
    check("r2_n_rstp",   n_rst_p,       7);
    check("r2_n_done",   n_run_done,    1);
    check("r2_n_busy",   n_busy,        18);

    // solve_div of zero behaves like one
    clr_counters();
    start_run(32'd3, 8'd0);
    set_levels(1'b1);
    wait_idle(100, "r3_timeout");
    set_levels(1'b0);
    tick();
    check("r3_cnt",     bus.cnt_out,   3);
    check("r3_n_solve", n_start_solve, 2);
    check("r3_n_busy",  n_busy,        10);

    // Staggered lane completion: lanes 0..3 pulse on cycles 5,2,9,2
    clr_counters();
    start_run(32'd1, 8'd1);
    seen_at = 0;
    for (int c = 1; c <= 12; c++) begin
      pd[0] = (c == 5);
      pd[1] = (c == 2);
      pd[2] = (c == 9);
      pd[3] = (c == 2);
      bus.pusher_done = pd;
      tick();
      if (bus.rst_pusher && seen_at == 0) seen_at = c;
    end
    bus.pusher_done = '0;
    check("r4_scatter_cycle", seen_at,     9);
    check("r4_cnt",           bus.cnt_out, 1);
    check("r4_busy",          bus.busy,    1);
    check("r4_n_rstp",        n_rst_p,     1);
    bus.scatter_done = '1; tick(); bus.scatter_done = '0;
    check("r4_run_done", bus.run_done, 1);
    tick();

    // Abort coincident with solver_done
    clr_counters();
    start_run(32'd5, 8'd1);
    bus.pusher_done = '1;  tick(); bus.pusher_done = '0;
    bus.scatter_done = '1; tick(); bus.scatter_done = '0;
    tick();
    check("r5_in_solve", bus.start_solve, 1);
    bus.solver_done = 1'b1;
    bus.abort       = 1'b1;
    tick();
    bus.solver_done = 1'b0;
    bus.abort       = 1'b0;
    check("r5_busy",     bus.busy,          0);
    check("r5_rstp",     bus.rst_pusher,    1);
    check("r5_rstsc",    bus.rst_scatterer, 1);
    check("r5_rstsv",    bus.rst_solver,    1);
    check("r5_run_done", bus.run_done,      0);
    check("r5_uiv",      bus.ui_valid,      1);
    check("r5_fifo",     bus.fifo_ready,    0);
    check("r5_cnt",      bus.cnt_out,       1);
    tick();
    check("r5_rstp_low", bus.rst_pusher, 0);
    check("r5_cnt_hold", bus.cnt_out,    1);
    check("r5_n_done",   n_run_done,     0);

    // Zero-length run
    clr_counters();
    start_run(32'd0, 8'd2);
    check("r6_busy",     bus.busy,     0);
    check("r6_run_done", bus.run_done, 1);
    tick();
    check("r6_run_done_low", bus.run_done, 0);
    tick();
    check("r6_n_busy",   n_busy,                   0);
    check("r6_n_done",   n_run_done,               1);
    check("r6_n_fr_tog", n_fr_tog,                 0);
    check("r6_n_rst",    n_rst_p + n_rst_sc + n_rst_sv, 0);
    check("r6_n_solve",  n_start_solve,            0);
    check("r6_cnt",      bus.cnt_out,              1);

    // Reset pulse while in SCATTER, then a clean run
    start_run(32'd5, 8'd1);
    bus.pusher_done = '1; tick(); bus.pusher_done = '0;
    check("r7_in_scatter", bus.rst_pusher, 1);
    rst_n = 1'b0;
    tick();
    check("r7_busy",  bus.busy,       0);
    check("r7_cnt",   bus.cnt_out,    0);
    check("r7_uiv",   bus.ui_valid,   1);
    check("r7_first", bus.first,      1);
    check("r7_fifo",  bus.fifo_ready, 0);
    check("r7_rstsv", bus.rst_solver, 1);
    rst_n = 1'b1;
    tick();
    check("r7_rel_rstp",  bus.rst_pusher,    0);
    check("r7_rel_rstsc", bus.rst_scatterer, 0);
    check("r7_rel_rstsv", bus.rst_solver,    0);
    clr_counters();
    start_run(32'd2, 8'd1);
    check("r7_new_cnt",   bus.cnt_out, 0);
    check("r7_new_first", bus.first,   1);
    check("r7_new_busy",  bus.busy,    1);
    set_levels(1'b1);
    wait_idle(100, "r7_timeout");
    set_levels(1'b0);
    tick();
    check("r7_end_cnt", bus.cnt_out, 2);
    check("r7_n_done",  n_run_done,  1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
